dram_burst_responder: RTL and testbench

Wishbone slave that models the DRAM side of the user-project DMA path: it holds a word-addressed memory, serves single reads and writes, and, when the DMA selects burst mode, prefetches sequential words into a small buffer so that back-to-back sequential reads are acknowledged every other cycle. It is the responder the DMA engine issues its burst reads to, and it sits between the user-project Wishbone interconnect and the on-chip DRAM model.

---
 rtl/dram_burst_responder.sv | 139 +++++++++++++
 tb/tb_dram_burst_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_burst_responder.sv
// dram_burst_responder: Wishbone slave modelling the DRAM side of the DMA path, with an optional sequential-read prefetch buffer.
// The prefetch engine and buffer are built only when DRAM_RESP_PREFETCH_EN is defined.
module dram_burst_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h3800_0000,
    parameter int          ADDR_WIDTH = 10,
    parameter int          DEPTH      = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        burst_en_i,
    output logic        burst_valid_o
);
    typedef enum logic [2:0] {IDLE, WR_ACK, RD_MEM, RD_ACK, RD_HIT} bus_state_t;

    logic [31:0]           mem [2**ADDR_WIDTH];
    bus_state_t            state_q, state_d;
    logic                  ack_q, ack_d;
    logic [31:0]           dat_q, dat_d;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  acc, wr_acc, rd_acc, hit;
    logic [31:0]           hit_data;
    logic                  unused;

    assign idx    = wbs_adr_i[ADDR_WIDTH+1:2];
    assign acc    = wbs_cyc_i & wbs_stb_i & ~ack_q & (state_q == IDLE)
                  & (wbs_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign wr_acc = acc & wbs_we_i;
    assign rd_acc = acc & ~wbs_we_i;

`ifdef DRAM_RESP_PREFETCH_EN
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic {PF_IDLE, PF_RUN} pf_state_t;

    logic [ADDR_WIDTH-1:0] tag_q [DEPTH];
    logic [31:0]           buf_q [DEPTH];
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    pf_state_t             pf_q, pf_d;
    logic [ADDR_WIDTH-1:0] pf_ptr_q, pf_ptr_d, fl_tag_q, fl_tag_d;
    logic [31:0]           fl_data_q, fl_data_d;
    logic                  fl_q, fl_d, miss_burst, flush, push, issue;

    assign hit           = rd_acc & burst_en_i & (count_q != '0) & (tag_q[rd_ptr_q] == idx);
    assign hit_data      = buf_q[rd_ptr_q];
    assign burst_valid_o = burst_en_i & (count_q != '0);
    assign unused        = ^wbs_adr_i[1:0];

    // The bus owns the memory port only on its accept edge; prefetch reads use every other cycle.
    always_comb begin
        miss_burst = rd_acc & burst_en_i & ~hit;
        flush      = wr_acc | ~burst_en_i | miss_burst;
        push       = fl_q & ~flush;
        issue      = (pf_q == PF_RUN) & ~flush & ~acc & ((count_q + CW'(fl_q)) < CW'(DEPTH));
        pf_d       = miss_burst ? PF_RUN : (wr_acc | ~burst_en_i) ? PF_IDLE : pf_q;
        pf_ptr_d   = miss_burst ? idx + 1'b1 : issue ? pf_ptr_q + 1'b1 : pf_ptr_q;
        fl_d       = issue;
        fl_tag_d   = pf_ptr_q;
        fl_data_d  = mem[pf_ptr_q];
        rd_ptr_d   = flush ? '0 : rd_ptr_q + PW'(hit);
        wr_ptr_d   = flush ? '0 : wr_ptr_q + PW'(push);
        count_d    = flush ? '0 : count_q + CW'(push) - CW'(hit);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            pf_q      <= PF_IDLE;
            pf_ptr_q  <= '0;
            fl_q      <= 1'b0;
            fl_tag_q  <= '0;
            fl_data_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            pf_q      <= pf_d;
            pf_ptr_q  <= pf_ptr_d;
            fl_q      <= fl_d;
            fl_tag_q  <= fl_tag_d;
            fl_data_q <= fl_data_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            tag_q[wr_ptr_q] <= fl_tag_q;
            buf_q[wr_ptr_q] <= fl_data_q;
        end
    end
`else
    assign hit           = 1'b0;
    assign hit_data      = '0;
    assign burst_valid_o = 1'b0;
    assign unused        = ^{wbs_adr_i[1:0], burst_en_i};
`endif

    // Miss data is captured at accept and held through RD_MEM; ack follows one cycle later.
    always_comb begin
        state_d = (state_q == RD_MEM) ? RD_ACK :
                  (state_q != IDLE)   ? IDLE   :
                  wr_acc              ? WR_ACK :
                  hit                 ? RD_HIT :
                  rd_acc              ? RD_MEM : IDLE;
        ack_d   = wr_acc | hit | (state_q == RD_MEM);
        dat_d   = hit ? hit_data : rd_acc ? mem[idx] : dat_q;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wr_acc)
            for (int b = 0; b < 4; b++)
                if (wbs_sel_i[b]) mem[idx][8*b +: 8] <= wbs_dat_i[8*b +: 8];
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
endmodule

// File: tb/tb_dram_burst_responder.sv
// tb_dram_burst_responder: randomized self-checking bench for dram_burst_responder.
// The reference treats a read as a buffer hit when burst mode has stayed on and it continues the previous read's stream.
module tb_dram_burst_responder;
    localparam logic [31:0] BASE = 32'h3800_0000;
`ifdef DRAM_RESP_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we_i = 1'b0, burst_en = 1'b0;
    logic [3:0]  sel_i = '0;
    logic [31:0] adr_i = '0, dat_i = '0;
    logic        ack, bv;
    logic [31:0] dat_o;

    int checks = 0;
    int failures = 0;

    logic [31:0] ref_mem [1024];
    bit          seq_ok = 1'b0;
    logic [9:0]  next_idx = '0;

    dram_burst_responder dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we_i),
        .wbs_sel_i(sel_i), .wbs_adr_i(adr_i), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .burst_en_i(burst_en), .burst_valid_o(bv)
    );

    always #5 clk = ~clk;

    function automatic int exp_lat(input logic [9:0] i);
        return (PF && burst_en && seq_ok && i == next_idx) ? 1 : 2;
    endfunction

    task automatic set_burst(input logic v);
        burst_en = v;
        if (!v) seq_ok = 1'b0;
    endtask

    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] sel,
                        output int lat, output logic [31:0] rd, output logic tail_ack, output logic tail_bv);
        cyc = 1'b1; stb = 1'b1; we_i = we; adr_i = adr; dat_i = wd; sel_i = sel;
        @(posedge clk); #1;
        lat = 1;
        while (ack !== 1'b1 && lat < 6) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = dat_o;
        cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
        @(posedge clk); #1;
        tail_ack = ack;
        tail_bv = bv;
    endtask

    task automatic bus_write(input logic [9:0] i, input logic [31:0] d, input logic [3:0] s,
                             output int lat, output logic tail);
        logic [31:0] rd;
        logic tb;
        xfer(1'b1, BASE + {20'd0, i, 2'b00}, d, s, lat, rd, tail, tb);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[i][8*b +: 8] = d[8*b +: 8];
        seq_ok = 1'b0;
    endtask

    task automatic bus_read(input logic [9:0] i, output int lat, output int elat, output logic [31:0] rd,
                            output logic [31:0] erd, output logic tail, output logic tbv);
        elat = exp_lat(i);
        erd = ref_mem[i];
        xfer(1'b0, BASE + {20'd0, i, 2'b00} + 32'($urandom_range(0, 3)), $urandom, 4'($urandom), lat, rd, tail, tbv);
        seq_ok = burst_en;
        next_idx = i + 10'd1;
    endtask

    task automatic test_reset;
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%0b exp=0", ack); end
        checks++; if (dat_o !== 32'h0) begin failures++; $display("FAIL reset_dat got=%h exp=0", dat_o); end
        checks++; if (bv !== 1'b0) begin failures++; $display("FAIL reset_bv got=%0b exp=0", bv); end
    endtask

    task automatic test_byte_lane;
        int lat, elat; logic [31:0] rd, erd; logic tail, tbv;
        set_burst(1'b0);
        bus_write(10'h4, 32'hDEADBEEF, 4'hF, lat, tail);
        checks++; if (lat !== 1) begin failures++; $display("FAIL wr_lat got=%0d exp=1", lat); end
        checks++; if (tail !== 1'b0) begin failures++; $display("FAIL wr_ack_width got=%0b exp=0", tail); end
        bus_read(10'h4, lat, elat, rd, erd, tail, tbv);
        checks++; if (lat !== 2) begin failures++; $display("FAIL rd_lat got=%0d exp=2", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
        checks++; if (tail !== 1'b0) begin failures++; $display("FAIL rd_ack_width got=%0b exp=0", tail); end
    endtask

    task automatic test_partial;
        int lat, elat; logic [31:0] rd, erd; logic tail, tbv;
        set_burst(1'b0);
        bus_write(10'h8, 32'h11223344, 4'hF, lat, tail);
        bus_write(10'h8, 32'hAABBCCDD, 4'b0101, lat, tail);
        checks++; if (lat !== 1) begin failures++; $display("FAIL partial_wr_lat got=%0d exp=1", lat); end
        bus_read(10'h8, lat, elat, rd, erd, tail, tbv);
        checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL partial_data got=%h exp=11bb33dd", rd); end
        checks++; if (lat !== elat) begin failures++; $display("FAIL partial_lat got=%0d exp=%0d", lat, elat); end
    endtask

    task automatic test_burst;
        int lat, elat; logic [31:0] rd, erd; logic tail, tbv;
        set_burst(1'b0);
        for (int i = 0; i < 8; i++) bus_write(10'(i), 32'(i) * 32'h100, 4'hF, lat, tail);
        set_burst(1'b1);
        for (int i = 0; i < 8; i++) begin
            bus_read(10'(i), lat, elat, rd, erd, tail, tbv);
            checks++; if (lat !== elat) begin failures++; $display("FAIL burst_lat[%0d] got=%0d exp=%0d", i, lat, elat); end
            checks++; if (rd !== 32'(i) * 32'h100) begin failures++; $display("FAIL burst_data[%0d] got=%h exp=%h", i, rd, 32'(i) * 32'h100); end
            if (i == 0) begin
                checks++; if (tbv !== PF) begin failures++; $display("FAIL burst_valid got=%0b exp=%0b", tbv, PF); end
            end
        end
    endtask

    task automatic test_coherence;
        int lat, elat; logic [31:0] rd, erd; logic tail, tbv;
        set_burst(1'b0);
        bus_write(10'd16, 32'h1600_0016, 4'hF, lat, tail);
        bus_write(10'd17, 32'h1700_0017, 4'hF, lat, tail);
        set_burst(1'b1);
        bus_read(10'd0, lat, elat, rd, erd, tail, tbv);
        bus_read(10'd1, lat, elat, rd, erd, tail, tbv);
        bus_read(10'd16, lat, elat, rd, erd, tail, tbv);
        checks++; if (lat !== 2) begin failures++; $display("FAIL coh_miss_lat got=%0d exp=2", lat); end
        checks++; if (rd !== 32'h1600_0016) begin failures++; $display("FAIL coh_miss_data got=%h exp=16000016", rd); end
        bus_write(10'd17, 32'h5A5A5A5A, 4'hF, lat, tail);
        bus_read(10'd17, lat, elat, rd, erd, tail, tbv);
        checks++; if (lat !== 2) begin failures++; $display("FAIL coh_lat got=%0d exp=2", lat); end
        checks++; if (rd !== 32'h5A5A5A5A) begin failures++; $display("FAIL coh_data got=%h exp=5a5a5a5a", rd); end
    endtask

    task automatic test_wrap;
        int lat, elat; logic [31:0] rd, erd; logic tail, tbv;
        logic [9:0] seq [4];
        seq = '{10'd1022, 10'd1023, 10'd0, 10'd1};
        set_burst(1'b0);
        foreach (seq[k]) bus_write(seq[k], $urandom, 4'hF, lat, tail);
        set_burst(1'b1);
        foreach (seq[k]) begin
            bus_read(seq[k], lat, elat, rd, erd, tail, tbv);
            checks++; if (lat !== elat) begin failures++; $display("FAIL wrap_lat[%0d] got=%0d exp=%0d", k, lat, elat); end
            checks++; if (rd !== erd) begin failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", k, rd, erd); end
        end
    endtask

    task automatic test_out_of_window;
        logic [31:0] adrs [2];
        int acks;
        adrs = '{32'h3900_0010, 32'h37FF_FFFC};
        foreach (adrs[k]) begin
            acks = 0;
            cyc = 1'b1; stb = 1'b1; we_i = k[0]; adr_i = adrs[k]; dat_i = 32'hFFFF_FFFF; sel_i = 4'hF;
            repeat (6) begin
                @(posedge clk); #1;
                if (ack === 1'b1) acks++;
            end
            cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
            @(posedge clk); #1;
            checks++; if (acks !== 0) begin failures++; $display("FAIL oow_ack[%0d] got=%0d exp=0", k, acks); end
        end
    endtask

    task automatic test_abort;
        set_burst(1'b0);
        cyc = 1'b1; stb = 1'b1; we_i = 1'b0; adr_i = BASE + 32'h10;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL abort_ack got=%0b exp=1", ack); end
        checks++; if (dat_o !== ref_mem[4]) begin failures++; $display("FAIL abort_data got=%h exp=%h", dat_o, ref_mem[4]); end
        @(posedge clk); #1;
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL abort_ack_width got=%0b exp=0", ack); end
    endtask

    task automatic test_reset_mid;
        int lat, elat, acks; logic [31:0] rd, erd; logic tail, tbv;
        set_burst(1'b1);
        bus_read(10'd0, lat, elat, rd, erd, tail, tbv);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (bv !== PF) begin failures++; $display("FAIL pre_rst_bv got=%0b exp=%0b", bv, PF); end
        rst_n = 1'b0; #1;
        checks++; if (bv !== 1'b0) begin failures++; $display("FAIL rst_bv got=%0b exp=0", bv); end
        #2 rst_n = 1'b1;
        seq_ok = 1'b0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we_i = 1'b0; adr_i = BASE + 32'h20;
        @(posedge clk); #1;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; #1;
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rdmem_rst_ack got=%0b exp=0", ack); end
        checks++; if (dat_o !== 32'h0) begin failures++; $display("FAIL rdmem_rst_dat got=%h exp=0", dat_o); end
        checks++; if (bv !== 1'b0) begin failures++; $display("FAIL rdmem_rst_bv got=%0b exp=0", bv); end
        @(posedge clk); #1 rst_n = 1'b1;
        acks = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack === 1'b1) acks++;
        end
        checks++; if (acks !== 0) begin failures++; $display("FAIL lost_ack got=%0d exp=0", acks); end
        cyc = 1'b1; stb = 1'b1; adr_i = BASE + 32'h10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL rdack_pre got=%0b exp=1", ack); end
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; #1;
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rdack_rst got=%0b exp=0", ack); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        bus_read(10'd0, lat, elat, rd, erd, tail, tbv);
        checks++; if (lat !== 2) begin failures++; $display("FAIL post_rst_lat got=%0d exp=2", lat); end
        checks++; if (rd !== erd) begin failures++; $display("FAIL post_rst_data got=%h exp=%h", rd, erd); end
    endtask

    task automatic test_random;
        int lat, elat, r; logic [31:0] rd, erd; logic tail, tbv;
        logic [9:0] i;
        set_burst(1'b0);
        for (int k = 0; k < 32; k++) bus_write(10'(k), $urandom, 4'hF, lat, tail);
        set_burst(1'b1);
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) set_burst(~burst_en);
            else if (r < 3) begin
                bus_write(10'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)), lat, tail);
                checks++; if (lat !== 1) begin failures++; $display("FAIL rnd_wr_lat[%0d] got=%0d exp=1", n, lat); end
            end else begin
                i = (seq_ok && next_idx < 10'd32 && r < 8) ? next_idx : 10'($urandom_range(0, 31));
                bus_read(i, lat, elat, rd, erd, tail, tbv);
                checks++; if (lat !== elat) begin failures++; $display("FAIL rnd_rd_lat[%0d] idx=%0d got=%0d exp=%0d", n, i, lat, elat); end
                checks++; if (rd !== erd) begin failures++; $display("FAIL rnd_rd_data[%0d] idx=%0d got=%h exp=%h", n, i, rd, erd); end
                checks++; if (tail !== 1'b0) begin failures++; $display("FAIL rnd_ack_width[%0d] got=%0b exp=0", n, tail); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        #3;
        test_reset;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset;
        test_byte_lane;
        test_partial;
        test_burst;
        test_coherence;
        test_wrap;
        test_out_of_window;
        test_abort;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
